// File: rtl/jt900h_div_seq.sv
// jt900h_div_seq: TLCS-900H DIV/DIVS sequencer.
// Uses bit-serial restoring division, one quotient bit per enabled cycle.
// Optional macro JT900H_DIVS_EN: when defined, sgn selects signed division.
// When it is undefined, sgn is ignored and every divide is unsigned.
// Parameter EARLY_OV: 1 lets a zero divisor or overflow found in PREP skip ITER.
module jt900h_div_seq #(
  parameter bit EARLY_OV = 1'b1
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        start,
  input  logic [1:0]  len,
  input  logic        sgn,
  input  logic [31:0] op0,
  input  logic [15:0] op1,
  output logic        busy,
  output logic        done,
  output logic [15:0] quot,
  output logic [15:0] rem,
  output logic        v
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

  state_t      r_state;
  logic        r_word, r_ill, r_sgn;
  logic [31:0] r_op0;
  logic [15:0] r_op1;
  logic [15:0] r_pr, r_dlo, r_dvs, r_q;
  logic [3:0]  r_cnt;
  logic        r_sign_q, r_sign_r, r_ovf;

  logic        w_sgn_in, w_sign0, w_sign1, w_pov, w_ge, w_sovf;
  logic [31:0] w_neg0, w_mag0;
  logic [15:0] w_neg1, w_mag1, w_hi, w_lo, w_sub;
  logic [16:0] w_sh;
  logic [15:0] w_qm, w_rm, w_qs, w_rs, w_qo, w_ro, w_lim, w_ones, w_ovh;

`ifdef JT900H_DIVS_EN
  assign w_sgn_in = sgn;
`else
  logic w_unused_sgn;
  assign w_unused_sgn = sgn;
  assign w_sgn_in     = 1'b0;
`endif

  // Operand magnitudes and the early overflow test (used in PREP)
  assign w_sign0 = r_sgn & (r_word ? r_op0[31] : r_op0[15]);
  assign w_sign1 = r_sgn & (r_word ? r_op1[15] : r_op1[7]);
  assign w_neg0  = ~r_op0 + 32'd1;
  assign w_neg1  = ~r_op1 + 16'd1;
  assign w_mag0  = r_word ? (w_sign0 ? w_neg0 : r_op0)
                          : {16'd0, (w_sign0 ? w_neg0[15:0] : r_op0[15:0])};
  assign w_mag1  = r_word ? (w_sign1 ? w_neg1 : r_op1)
                          : {8'd0, (w_sign1 ? w_neg1[7:0] : r_op1[7:0])};
  assign w_hi    = r_word ? w_mag0[31:16] : {8'd0, w_mag0[15:8]};
  assign w_lo    = r_word ? w_mag0[15:0]  : {w_mag0[7:0], 8'd0};
  assign w_pov   = (w_mag1 == 16'd0) | (w_hi >= w_mag1);

  // One restoring step: the partial remainder stays below the divisor, so 17 bits hold the shift
  assign w_sh  = {r_pr, r_dlo[15]};
  assign w_ge  = w_sh >= {1'b0, r_dvs};
  assign w_sub = w_sh[15:0] - r_dvs;

  // Sign fix-up and signed overflow (used in FIX)
  assign w_qm   = r_word ? r_q  : {8'd0, r_q[7:0]};
  assign w_rm   = r_word ? r_pr : {8'd0, r_pr[7:0]};
  assign w_lim  = r_word ? 16'h8000 : 16'h0080;
`ifdef JT900H_DIVS_EN
  assign w_sovf = r_sgn & (r_sign_q ? (w_qm > w_lim) : (w_qm >= w_lim));
`else
  assign w_sovf = 1'b0;
`endif
  assign w_qs   = (r_sgn & r_sign_q) ? 16'(~w_qm + 16'd1) : w_qm;
  assign w_rs   = (r_sgn & r_sign_r) ? 16'(~w_rm + 16'd1) : w_rm;
  assign w_qo   = r_word ? w_qs : {8'd0, w_qs[7:0]};
  assign w_ro   = r_word ? w_rs : {8'd0, w_rs[7:0]};
  assign w_ones = (r_word | r_ill) ? 16'hFFFF : 16'h00FF;
  assign w_ovh  = (r_word | r_ill) ? r_op0[31:16] : {8'd0, r_op0[15:8]};

  // Sequencer: IDLE -> PREP -> ITER (W cycles) -> FIX -> IDLE, advancing on cen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_word   <= 1'b0;
      r_ill    <= 1'b0;
      r_sgn    <= 1'b0;
      r_op0    <= 32'd0;
      r_op1    <= 16'd0;
      r_pr     <= 16'd0;
      r_dlo    <= 16'd0;
      r_dvs    <= 16'd0;
      r_q      <= 16'd0;
      r_cnt    <= 4'd0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_ovf    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= 16'd0;
      rem      <= 16'd0;
      v        <= 1'b0;
    end else if (cen) begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_op0   <= op0;
            r_op1   <= op1;
            r_word  <= (len == 2'b01);
            r_ill   <= len[1];
            r_sgn   <= w_sgn_in;
            busy    <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_pr     <= w_hi;
          r_dlo    <= w_lo;
          r_dvs    <= w_mag1;
          r_sign_q <= w_sign0 ^ w_sign1;
          r_sign_r <= w_sign0;
          r_ovf    <= w_pov | r_ill;
          r_cnt    <= r_word ? 4'd15 : 4'd7;
          r_state  <= (r_ill || (EARLY_OV && w_pov)) ? S_FIX : S_ITER;
        end
        S_ITER: begin
          r_pr  <= w_ge ? w_sub : w_sh[15:0];
          r_q   <= {r_q[14:0], w_ge};
          r_dlo <= {r_dlo[14:0], 1'b0};
          if (r_cnt == 4'd0) r_state <= S_FIX;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_FIX: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
          if (r_ovf | w_sovf) begin
            v    <= 1'b1;
            quot <= w_ones;
            rem  <= w_ovh;
          end else begin
            v    <= 1'b0;
            quot <= w_qo;
            rem  <= w_ro;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
